// File: rtl/usr_seq_shifter_if.sv
// Handshake and data bundle for the universal sequential shifter.
// The master drives the request; the slave (the shifter) returns its state.
interface usr_seq_shifter_if #(
    parameter int W  = 8,
    parameter int AW = $clog2(W + 1)
);
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          si;
    logic [W-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;

    modport master (
        output start, op, amt, d, si,
        input  q, so, busy, done
    );

    modport slave (
        input  start, op, amt, d, si,
        output q, so, busy, done
    );
endinterface

// File: rtl/usr_seq_shifter.sv
// W-bit universal shift/rotate register, one bit per cycle with start/busy/done.
// Define USR_BARREL_EN to finish shifts and rotates in a single cycle.
module usr_seq_shifter #(
    parameter int W  = 8,
    parameter int AW = $clog2(W + 1)
) (
    input logic              c,
    input logic              rst,
    usr_seq_shifter_if.slave bus
);
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ASR  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [W-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;
    logic [AW-1:0] cnt;
    logic [2:0]    lop;

    // Returns {so, q} after one single-bit step.
    function automatic logic [W:0] step(
        input logic [2:0]   o,
        input logic [W-1:0] x,
        input logic         s
    );
        case (o)
            OP_SHL:  step = {x[W-1], x[W-2:0], s};
            OP_SHR:  step = {x[0], s, x[W-1:1]};
            OP_ROL:  step = {x[W-1], x[W-2:0], x[W-1]};
            OP_ROR:  step = {x[0], x[0], x[W-1:1]};
            OP_ASR:  step = {x[0], x[W-1], x[W-1:1]};
            default: step = {1'b0, x};
        endcase
    endfunction

`ifdef USR_BARREL_EN
    // Whole k-step result at once; only called with k >= 1.
    function automatic logic [W:0] barrel(
        input logic [2:0]    o,
        input logic [W-1:0]  x,
        input logic          s,
        input logic [AW-1:0] k
    );
        int n;
        int ks;
        int r;
        logic [W-1:0] lo_fill;
        logic [W-1:0] hi_fill;
        logic [W-1:0] res;
        logic         out;
        n       = int'(k);
        ks      = (n > W) ? W : n;
        r       = n % W;
        lo_fill = s ? ~({W{1'b1}} << ks) : '0;
        hi_fill = s ? ~({W{1'b1}} >> ks) : '0;
        res     = x;
        out     = 1'b0;
        case (o)
            OP_SHL: begin
                res = (x << ks) | lo_fill;
                out = (n > W) ? s : x[W-n];
            end
            OP_SHR: begin
                res = (x >> ks) | hi_fill;
                out = (n > W) ? s : x[n-1];
            end
            OP_ROL: begin
                res = (x << r) | (x >> (W - r));
                out = x[W-1-((n-1)%W)];
            end
            OP_ROR: begin
                res = (x >> r) | (x << (W - r));
                out = x[(n-1)%W];
            end
            OP_ASR: begin
                res = W'($signed(x) >>> ks);
                out = (n > W) ? x[W-1] : x[n-1];
            end
            default: res = x;
        endcase
        return {out, res};
    endfunction
`endif

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            lop   <= OP_NOP;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_LOAD: begin
                                q    <= bus.d;
                                done <= 1'b1;
                            end
                            OP_CLR: begin
                                q    <= '0;
                                done <= 1'b1;
                            end
                            OP_NOP: done <= 1'b1;
                            default: begin
                                if (bus.amt == '0) begin
                                    done <= 1'b1;
                                end else begin
`ifdef USR_BARREL_EN
                                    {so, q} <= barrel(bus.op, q, bus.si, bus.amt);
                                    done    <= 1'b1;
`else
                                    {so, q} <= step(bus.op, q, bus.si);
                                    if (bus.amt == ONE) begin
                                        done <= 1'b1;
                                    end else begin
                                        lop   <= bus.op;
                                        cnt   <= bus.amt - ONE;
                                        state <= RUN;
                                        busy  <= 1'b1;
                                    end
`endif
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    {so, q} <= step(lop, q, bus.si);
                    cnt     <= cnt - ONE;
                    if (cnt == ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.q    = q;
    assign bus.so   = so;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_usr_seq_shifter.sv
// Self-checking bench for usr_seq_shifter (W=8): vector table,
// hand-written corner sequences and random ops against a reference model.
module tb_usr_seq_shifter;
    logic c;
    logic rst;
    int   checks;
    int   errors;
    bit [7:0] mq;
    bit       mso;

    usr_seq_shifter_if #(.W(8)) bus ();

    usr_seq_shifter #(.W(8)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    typedef struct {
        bit [7:0] pre;
        bit [2:0] op;
        bit [3:0] amt;
        bit       si;
        bit [7:0] eq;
        bit       eso;
        bit       cso;
        string    name;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each step is expressed as integer arithmetic on the value.
    function automatic void model(input bit [2:0] op, input int amt, input bit [7:0] d, input bit si);
        int t;
        case (op)
            3'd0: mq = d;
            3'd6: mq = 8'd0;
            3'd7: ;
            default: begin
                for (int i = 0; i < amt; i++) begin
                    t = int'(mq);
                    case (op)
                        3'd1: begin mso = (t >= 128); mq = 8'((t * 2) % 256 + int'(si)); end
                        3'd2: begin mso = (t % 2 == 1); mq = 8'(t / 2 + int'(si) * 128); end
                        3'd3: begin mso = (t >= 128); mq = 8'((t * 2) % 256 + t / 128); end
                        3'd4: begin mso = (t % 2 == 1); mq = 8'(t / 2 + (t % 2) * 128); end
                        default: begin mso = (t % 2 == 1); mq = 8'(t / 2 + (t / 128) * 128); end
                    endcase
                end
            end
        endcase
    endfunction

    function automatic int latency(input bit [2:0] op, input int amt);
`ifdef USR_BARREL_EN
        return 1;
`else
        if (op >= 3'd1 && op <= 3'd5 && amt > 1) return amt;
        return 1;
`endif
    endfunction

    // Called just after a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input bit [2:0] op, input bit [3:0] amt, input bit [7:0] d,
                          input bit si, input string name,
                          output logic [7:0] gq, output logic gso);
        int lat;
        lat       = latency(op, int'(amt));
        bus.start = 1'b1;
        bus.op    = op;
        bus.amt   = amt;
        bus.d     = d;
        bus.si    = si;
        @(posedge c);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge c);
            chk({name, " busy/done"}, {30'd0, bus.busy, bus.done}, {30'd0, n < lat, n == lat});
        end
        gq  = bus.q;
        gso = bus.so;
    endtask

    initial begin
        logic [7:0] gq;
        logic       gso;
        int         lat;
        bit [2:0]   rop;
        bit [3:0]   ramt;
        bit [7:0]   rd;
        bit         rsi;

        checks = 0;
        errors = 0;
        mq     = 8'd0;
        mso    = 1'b0;

        vt[0]  = '{8'hA5, 3'd1, 4'd3,  1'b1, 8'h2F, 1'b1, 1'b1, "shl3"};
        vt[1]  = '{8'h81, 3'd4, 4'd9,  1'b0, 8'hC0, 1'b1, 1'b1, "ror9"};
        vt[2]  = '{8'h90, 3'd5, 4'd2,  1'b0, 8'hE4, 1'b0, 1'b1, "asr2"};
        vt[3]  = '{8'h5A, 3'd1, 4'd0,  1'b1, 8'h5A, 1'b0, 1'b0, "shl0"};
        vt[4]  = '{8'hC3, 3'd2, 4'd8,  1'b0, 8'h00, 1'b1, 1'b1, "shr8"};
        vt[5]  = '{8'h3C, 3'd3, 4'd4,  1'b0, 8'hC3, 1'b1, 1'b1, "rol4"};
        vt[6]  = '{8'h01, 3'd1, 4'd12, 1'b1, 8'hFF, 1'b1, 1'b1, "shl12"};
        vt[7]  = '{8'h80, 3'd2, 4'd1,  1'b1, 8'hC0, 1'b0, 1'b1, "shr1"};
        vt[8]  = '{8'h7F, 3'd5, 4'd10, 1'b0, 8'h00, 1'b0, 1'b1, "asr10"};
        vt[9]  = '{8'hAA, 3'd6, 4'd0,  1'b0, 8'h00, 1'b0, 1'b0, "clr"};
        vt[10] = '{8'h12, 3'd7, 4'd5,  1'b0, 8'h12, 1'b0, 1'b0, "nop"};
        vt[11] = '{8'h96, 3'd4, 4'd8,  1'b1, 8'h96, 1'b1, 1'b1, "ror8"};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.amt   = '0;
        bus.d     = 8'd0;
        bus.si    = 1'b0;
        @(negedge c);
        chk("reset state", {21'd0, bus.q, bus.so, bus.busy, bus.done}, 32'd0);
        rst = 1'b0;
        @(negedge c);

        run_op(3'd0, 4'd0, 8'hA5, 1'b0, "load A5", gq, gso);
        model(3'd0, 0, 8'hA5, 1'b0);
        chk("load A5 q", {24'd0, gq}, 32'h0000_00A5);

        // Each op starts in the previous op's done cycle.
        foreach (vt[i]) begin
            run_op(3'd0, 4'd0, vt[i].pre, 1'b0, {vt[i].name, " pre"}, gq, gso);
            model(3'd0, 0, vt[i].pre, 1'b0);
            chk({vt[i].name, " pre q"}, {24'd0, gq}, {24'd0, vt[i].pre});
            run_op(vt[i].op, vt[i].amt, 8'h00, vt[i].si, vt[i].name, gq, gso);
            model(vt[i].op, int'(vt[i].amt), 8'h00, vt[i].si);
            chk({vt[i].name, " q"}, {24'd0, gq}, {24'd0, vt[i].eq});
            if (vt[i].cso) chk({vt[i].name, " so"}, {31'd0, gso}, {31'd0, vt[i].eso});
        end

        // Starts while busy must be ignored.
        run_op(3'd0, 4'd0, 8'h81, 1'b0, "ign pre", gq, gso);
        model(3'd0, 0, 8'h81, 1'b0);
        lat       = latency(3'd4, 9);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.amt   = 4'd9;
        bus.si    = 1'b0;
        @(posedge c);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge c);
            chk("ign busy/done", {30'd0, bus.busy, bus.done}, {30'd0, n < lat, n == lat});
            bus.start = (n < lat - 1) && (n % 2 == 1);
            bus.op    = 3'd0;
            bus.d     = 8'hFF;
        end
        model(3'd4, 9, 8'h00, 1'b0);
        chk("ign q", {24'd0, bus.q}, 32'h0000_00C0);
        chk("ign so", {31'd0, bus.so}, 32'd1);

        // Done must be a single-cycle pulse.
        @(negedge c);
        chk("done drop", {31'd0, bus.done}, 32'd0);

        // Reset in the middle of a long shift.
        run_op(3'd0, 4'd0, 8'h3D, 1'b0, "rmid pre", gq, gso);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.amt   = 4'd6;
        bus.si    = 1'b1;
        @(posedge c);
        #1 bus.start = 1'b0;
        @(posedge c);
        #2 rst = 1'b1;
        #1 chk("rmid clear", {21'd0, bus.q, bus.so, bus.busy, bus.done}, 32'd0);
        @(negedge c);
        rst = 1'b0;
        mq  = 8'd0;
        mso = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge c);
            chk("rmid quiet", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        chk("rmid q", {24'd0, bus.q}, 32'd0);

        // Random ops against the reference model.
        for (int i = 0; i < 80; i++) begin
            rop  = 3'($urandom_range(0, 7));
            ramt = 4'($urandom_range(0, 11));
            rd   = 8'($urandom);
            rsi  = 1'($urandom);
            run_op(rop, ramt, rd, rsi, "rand", gq, gso);
            model(rop, int'(ramt), rd, rsi);
            chk("rand q", {24'd0, gq}, {24'd0, mq});
            chk("rand so", {31'd0, gso}, {31'd0, mso});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usr_seq_shifter.md
Name: usr_seq_shifter

Overview:
Parametrised, clocked successor to the team's 8-bit universal shift register (hold/shift-left/shift-right/parallel-load). Generalised to W bits. Adds rotate, arithmetic shift, clear, multi-position shifts executed one bit per cycle, a serial-out bit, and a start/busy/done handshake. Used as the shift/rotate unit behind the team's small datapath and ALU exercises.

Parameters:
W, 8, register width in bits (W >= 2)
AW, $clog2(W+1), width of the shift-amount input

Ports:
c  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when idle
op  input  3  operation: 0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6 CLR, 7 NOP
amt  input  AW  number of single-bit steps for ops 1-5
d  input  W  parallel load data
si  input  1  serial input bit: enters bit 0 on SHL, enters bit W-1 on SHR
q  output  W  register contents
so  output  1  last bit shifted or rotated out
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse when an accepted operation completes

Behaviour:
- Reset (asynchronous, any time, including mid-operation): q=0, so=0, busy=0, done=0, step counter=0, FSM=IDLE. The in-flight operation is discarded.
- FSM has two states, IDLE and RUN. busy=1 exactly while in RUN.
- Single-step semantics, with qo = q before the edge:
  - SHL: q={qo[W-2:0],si}, so=qo[W-1].
  - SHR: q={si,qo[W-1:1]}, so=qo[0].
  - ROL: q={qo[W-2:0],qo[W-1]}, so=qo[W-1].
  - ROR: q={qo[0],qo[W-1:1]}, so=qo[0].
  - ASR: q={qo[W-1],qo[W-1:1]}, so=qo[0]; si is ignored.
- si is sampled on every step edge, not latched at start.
- IDLE with start=1, at edge E0:
  - LOAD: q=d; done=1 next cycle.
  - CLR: q=0; done=1 next cycle.
  - NOP: q unchanged; done=1 next cycle.
  - Ops 1-5 with amt=0: q and so unchanged; done=1 next cycle.
  - Ops 1-5 with amt=1: one step at E0; done=1 next cycle; stay IDLE.
  - Ops 1-5 with amt=k>1: one step at E0; latch op; counter=k-1; go to RUN.
- RUN, at each edge: one step; counter decrements. On the edge where counter goes 1->0: go to IDLE, done=1 for the next cycle only.
- Latency: an op with amt=k>=1 finishes after k edges counted from E0. done is high in the same cycle the final q is visible.
- amt>W is legal and executed literally:
  - SHL/SHR: the register fills with si values.
  - ROL/ROR: the result equals rotation by amt mod W, but still takes amt cycles.
- start while busy: ignored; op, amt and d are not re-sampled.
- start in the done cycle (IDLE): accepted normally, so back-to-back ops are allowed.
- Outside a step, so holds its last value. LOAD, CLR and NOP do not change so.

Optional Feature:
Macro USR_BARREL_EN.
- Defined: ops 1-5 complete at E0 in a single cycle using a barrel network.
  - q equals the k-step result, with shift amounts saturated at W for SHL/SHR/ASR. For SHL/SHR, the shifted-in positions all take the single sampled si.
  - so equals the last bit that would have left in bit-serial order; when amt>W for SHL/SHR, so=si.
  - busy is never asserted; done=1 the following cycle.
- Undefined: bit-serial behaviour as above.
- Port list is identical either way.

Test Plan:
- Reset then LOAD: rst pulse, then start, op=0, d=8'hA5 -> q=8'hA5 and done=1 one cycle later, busy=0 throughout.
- Multi-cycle SHL: q=8'hA5, op=1, amt=3, si=1 -> busy for 2 cycles; after 3 edges q=8'h2F, so=1, single done pulse.
- Rotate and wrap: q=8'h81, op=4 (ROR), amt=9 -> q=8'hC0 after 9 edges, so=1; start pulses during busy are ignored (q is not reloaded).
- ASR sign fill: q=8'h90, op=5, amt=2, si=0 -> q=8'hE4, so=0.
- Boundary cases:
  - amt=0 with op=1 -> q unchanged and done after one cycle.
  - amt=8 with op=2 (SHR), si=0 -> q=0.
  - Back-to-back start in the done cycle is accepted.
- Reset mid-op: SHL, amt=6; assert rst after 2 edges -> q=0, busy=0, done=0 immediately. No done pulse follows.
